// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and constants for the branch-predictor PHT:
//            counter width, 2-bit counter encodings and control FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  localparam int CNT_W = 2;

  // Saturating counter encodings; bit 1 is the predicted direction
  localparam logic [CNT_W-1:0] SNT = 2'b00;  // strongly not taken
  localparam logic [CNT_W-1:0] WNT = 2'b01;  // weakly not taken
  localparam logic [CNT_W-1:0] WT  = 2'b10;  // weakly taken
  localparam logic [CNT_W-1:0] ST  = 2'b11;  // strongly taken

  // Table control: INIT sweeps every entry, RUN serves traffic
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/sat_cnt_upd.sv
`default_nettype none
// ============================================================================
// Module   : sat_cnt_upd
// Purpose  : Combinational 2-bit saturating counter step. Taken moves the
//            counter toward ST, not-taken toward SNT, clamping at both ends.
// Revision : 1.0 - initial release
// ============================================================================
module sat_cnt_upd
  import bp_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_out
);

  // Step one position in the outcome direction, holding at the extremes
  always_comb begin
    cnt_out = cnt_in;
    if (taken) begin
      if (cnt_in != ST) cnt_out = cnt_in + 2'd1;
    end else begin
      if (cnt_in != SNT) cnt_out = cnt_in - 2'd1;
    end
  end

endmodule : sat_cnt_upd
`default_nettype wire

// File: rtl/bp_pht.sv
`default_nettype none
// ============================================================================
// Module   : bp_pht
// Purpose  : Pattern history table of 2-bit saturating counters. Registered
//            lookup port plus a two-stage read-modify-write update pipeline
//            with forwarding so back-to-back updates behave serially.
// Revision : 1.0 - initial release
// ============================================================================
module bp_pht
  import bp_pkg::*;
#(
  parameter int               IDX_W    = 4,
  parameter logic [CNT_W-1:0] INIT_CNT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CNT_W-1:0] pred_cnt,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  output logic             up_done,
  output logic [CNT_W-1:0] up_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CNT_W-1:0] table_q [DEPTH];

  state_e           state_q;
  logic [IDX_W-1:0] init_ptr_q;
  logic             ready_q;

  // S1 registers; the cycle after capture is the S2 compute/write cycle
  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_taken_q;
  logic [CNT_W-1:0] s1_cnt_q;

  logic             pred_valid_q;
  logic [CNT_W-1:0] pred_cnt_q;

  logic [CNT_W-1:0] s2_cnt_d;   // value S2 writes back this cycle
  logic             s2_wr;      // S2 write happens at the coming edge
  logic [CNT_W-1:0] lk_cnt_d;   // forwarded value for the lookup port
  logic [CNT_W-1:0] s1_cnt_d;   // forwarded value for the S1 capture

  sat_cnt_upd u_sat_cnt_upd (
    .cnt_in  (s1_cnt_q),
    .taken   (s1_taken_q),
    .cnt_out (s2_cnt_d)
  );

  // A reset arriving in the S2 cycle kills the write-back and its pulse
  assign s2_wr = s1_valid_q && !reset;

  // Bypass the in-flight S2 write so readers see serial ordering
  always_comb begin
    lk_cnt_d = table_q[lk_idx];
    s1_cnt_d = table_q[up_idx];
    if (s1_valid_q && (s1_idx_q == lk_idx)) lk_cnt_d = s2_cnt_d;
    if (s1_valid_q && (s1_idx_q == up_idx)) s1_cnt_d = s2_cnt_d;
  end

  // Control FSM: sweep every entry after reset, then serve traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_ptr_q <= init_ptr_q + 1'b1;
          if (init_ptr_q == {IDX_W{1'b1}}) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Counter storage: written only by the INIT sweep or the S2 write-back
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        table_q[init_ptr_q] <= INIT_CNT;
      end else if (s1_valid_q) begin
        table_q[s1_idx_q] <= s2_cnt_d;
      end
    end
  end

  // Update pipeline S1 capture of index, outcome and forwarded counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_taken_q <= 1'b0;
      s1_cnt_q   <= '0;
    end else begin
      s1_valid_q <= up_valid && ready_q;
      if (up_valid && ready_q) begin
        s1_idx_q   <= up_idx;
        s1_taken_q <= up_taken;
        s1_cnt_q   <= s1_cnt_d;
      end
    end
  end

  // Lookup port: one-cycle registered prediction, value held when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_cnt_q   <= '0;
    end else begin
      pred_valid_q <= lk_valid && ready_q;
      if (lk_valid && ready_q) pred_cnt_q <= lk_cnt_d;
    end
  end

  assign ready      = ready_q;
  assign pred_valid = pred_valid_q;
  assign pred_cnt   = pred_cnt_q;
  assign pred_taken = pred_cnt_q[1];
  assign up_done    = s2_wr;
  assign up_cnt     = s2_wr ? s2_cnt_d : '0;

endmodule : bp_pht
`default_nettype wire

// File: tb/tb_bp_pht.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_pht
// Purpose  : Self-checking bench for bp_pht (IDX_W=4). Expected predictions
//            and write-backs come from a serial table model and are queued
//            when stimulus is driven, then popped as the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_pht;

  logic       clk;
  logic       reset;
  logic       ready;
  logic       lk_valid;
  logic [3:0] lk_idx;
  logic       pred_valid;
  logic       pred_taken;
  logic [1:0] pred_cnt;
  logic       up_valid;
  logic [3:0] up_idx;
  logic       up_taken;
  logic       up_done;
  logic [1:0] up_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] mdl [16];
  bit         m_ready = 1'b0;
  logic [1:0] exp_pred_q [$];
  logic [1:0] exp_up_q   [$];
  logic [1:0] e_pred;
  logic [1:0] e_up;

  bp_pht #(
    .IDX_W    (4),
    .INIT_CNT (2'b01)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .lk_valid   (lk_valid),
    .lk_idx     (lk_idx),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_cnt   (pred_cnt),
    .up_valid   (up_valid),
    .up_idx     (up_idx),
    .up_taken   (up_taken),
    .up_done    (up_done),
    .up_cnt     (up_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference saturating step
  function automatic logic [1:0] model_next(input logic [1:0] c, input bit t);
    case ({t, c})
      3'b1_00: return 2'b01;
      3'b1_01: return 2'b10;
      3'b1_10: return 2'b11;
      3'b1_11: return 2'b11;
      3'b0_00: return 2'b00;
      3'b0_01: return 2'b00;
      3'b0_10: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Scoreboard consumer for both output streams
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      n_checks++;
      if (exp_pred_q.size() == 0) begin
        n_fail++;
        $display("FAIL pred_unexpected: pred_valid=1 pred_cnt=%b, required no prediction", pred_cnt);
      end else begin
        e_pred = exp_pred_q.pop_front();
        if (pred_cnt !== e_pred || pred_taken !== e_pred[1]) begin
          n_fail++;
          $display("FAIL pred_value: pred_cnt=%b pred_taken=%b, required %b/%b",
                   pred_cnt, pred_taken, e_pred, e_pred[1]);
        end
      end
    end
    if (up_done === 1'b1) begin
      n_checks++;
      if (exp_up_q.size() == 0) begin
        n_fail++;
        $display("FAIL up_unexpected: up_done=1 up_cnt=%b, required no write-back", up_cnt);
      end else begin
        e_up = exp_up_q.pop_front();
        if (up_cnt !== e_up) begin
          n_fail++;
          $display("FAIL up_value: up_cnt=%b, required %b", up_cnt, e_up);
        end
      end
    end
  end

  // Drive one cycle of stimulus; queue what the serial model predicts
  task automatic drive(input bit lkv, input logic [3:0] lki,
                       input bit upv, input logic [3:0] upi, input bit upt);
    lk_valid = lkv; lk_idx = lki;
    up_valid = upv; up_idx = upi; up_taken = upt;
    if (m_ready) begin
      if (lkv) exp_pred_q.push_back(mdl[lki]);
      if (upv) begin
        mdl[upi] = model_next(mdl[upi], upt);
        exp_up_q.push_back(mdl[upi]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 2'b01;
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1; lk_valid = 1'b0; up_valid = 1'b0;
    lk_idx = '0; up_idx = '0; up_taken = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({ready, pred_valid, pred_taken, pred_cnt, up_done, up_cnt} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b pv=%b pt=%b pc=%b ud=%b uc=%b, required all 0",
               ready, pred_valid, pred_taken, pred_cnt, up_done, up_cnt);
    end
    reset = 1'b0;
    model_reset();
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL init_length: ready after %0d cycles, required 16", cyc);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_init_lookups();
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 1'b0, 4'd0, 1'b0);
    idle(2);
    n_checks++;
    if (exp_pred_q.size() != 0) begin
      n_fail++;
      $display("FAIL init_lookups_drain: %0d pending, required 0", exp_pred_q.size());
    end
  endtask

  task automatic test_saturate_taken();
    drive(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);   // 01 -> 10
    drive(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);   // 10 -> 11 via S1 forwarding
    drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);   // lookup during S2 write -> 11
    drive(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);   // saturates at 11
    idle(3);
    n_checks++;
    if (exp_up_q.size() != 0 || exp_pred_q.size() != 0) begin
      n_fail++;
      $display("FAIL saturate_drain: %0d/%0d pending, required 0/0",
               exp_up_q.size(), exp_pred_q.size());
    end
    n_checks++;
    if (mdl[3] !== 2'b11) begin
      n_fail++;
      $display("FAIL saturate_model: idx3=%b, required 11", mdl[3]);
    end
  endtask

  task automatic test_not_taken_interleave();
    drive(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd6, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 4'd0, 1'b1, 4'd2, 1'b1);   // independent lookup + update
    drive(1'b1, 4'd2, 1'b1, 4'd2, 1'b0);   // lookup sees S2 value 10
    idle(3);
    n_checks++;
    if (exp_up_q.size() != 0 || exp_pred_q.size() != 0) begin
      n_fail++;
      $display("FAIL not_taken_drain: %0d/%0d pending, required 0/0",
               exp_up_q.size(), exp_pred_q.size());
    end
  endtask

  task automatic test_forward_lookup();
    drive(1'b0, 4'd0, 1'b1, 4'd9, 1'b1);   // S1 capture
    drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b0);   // lookup in the S2 cycle -> 10
    idle(2);
    n_checks++;
    if (exp_pred_q.size() != 0) begin
      n_fail++;
      $display("FAIL forward_drain: %0d pending, required 0", exp_pred_q.size());
    end
  endtask

  task automatic test_ready_low();
    int cyc;
    reset = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 1'b1, 4'(i), 1'b1);
    cyc = 10;
    while (ready !== 1'b1 && cyc < 40) begin
      drive(1'b1, 4'(cyc), 1'b1, 4'(cyc), 1'b0);
      cyc++;
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL reinit_length: ready after %0d cycles, required 16", cyc);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 1'b0, 4'd0, 1'b0);
    idle(2);
    n_checks++;
    if (exp_pred_q.size() != 0) begin
      n_fail++;
      $display("FAIL ready_low_drain: %0d pending, required 0", exp_pred_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);   // idx7 01 -> 10
    idle(2);
    // Second update is captured, then reset lands in its S2 cycle
    lk_valid = 1'b0; up_valid = 1'b1; up_idx = 4'd7; up_taken = 1'b1;
    @(posedge clk); #1;
    up_valid = 1'b0; reset = 1'b1; m_ready = 1'b0;
    #1;
    n_checks++;
    if (up_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_done: up_done=%b, required 0", up_done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL reset_mid_init: ready after %0d cycles, required 16", cyc);
    end
    m_ready = 1'b1;
    drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);   // back to 01
    idle(2);
    n_checks++;
    if (exp_pred_q.size() != 0 || exp_up_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: %0d/%0d pending, required 0/0",
               exp_pred_q.size(), exp_up_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_init_lookups();
    test_saturate_taken();
    test_not_taken_interleave();
    test_forward_lookup();
    test_ready_low();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bp_pht
`default_nettype wire
